// File: rtl/d7seg_scan_if.sv
// Bus between the datapath and the 7-segment scanner: the load-side word and the display pins.
// The master side loads the shadow word and the slave side drives the anodes and segments.
interface d7seg_scan_if #(
  parameter int NDIG = 4
);
  logic              load;
  logic [4*NDIG-1:0] data;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   dig_en;
  logic [NDIG-1:0]   an;
  logic [6:0]        seg;
  logic              dp_n;
  logic              frame_tick;

  modport master (
    output load, data, dp, dig_en,
    input  an, seg, dp_n, frame_tick
  );

  modport slave (
    input  load, data, dp, dig_en,
    output an, seg, dp_n, frame_tick
  );
endinterface

// File: rtl/d7seg_scan.sv
// Multiplexed NDIG-digit common-anode 7-segment driver with a shadow register and an anti-ghost blank window.
// Optional leading-zero blanking is enabled by defining D7SEG_SCAN_LZB_EN.
module d7seg_scan #(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  d7seg_scan_if.slave   bus
);

  localparam int PW    = $clog2(SCAN_DIV);
  localparam int IW    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int NSLOT = 1 << IW;
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  generate
    if (NDIG < 1 || NDIG > 8) begin : g_bad_ndig
      $error("d7seg_scan: NDIG must be in 1..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
      $error("d7seg_scan: SCAN_DIV must be >= 2");
    end
    if (BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
      $error("d7seg_scan: BLANK_CYC must be in 0..SCAN_DIV-1");
    end
  endgenerate

  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] data_q;
  logic [NDIG-1:0]   dp_q;
  logic [NDIG-1:0]   en_q;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;
  logic              frame_tick_q;
  logic              slot_end;
  logic              wrap;
  logic              in_blank;

  // Per-slot views padded to a power of two so idx_q never indexes past the array.
  logic [3:0]        nib [NSLOT];
  logic [NSLOT-1:0]  en_ext;
  logic [NSLOT-1:0]  dp_ext;
  logic [NSLOT-1:0]  lzb_mask;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NDIG) begin : g_real
        assign nib[gi]    = data_q[4*gi +: 4];
        assign en_ext[gi] = en_q[gi];
        assign dp_ext[gi] = dp_q[gi];
      end else begin : g_pad
        assign nib[gi]    = 4'h0;
        assign en_ext[gi] = 1'b0;
        assign dp_ext[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef D7SEG_SCAN_LZB_EN
  // Walk from the most significant digit down; digit 0 is deliberately excluded.
  always_comb begin : lzb_calc
    logic all_zero;
    lzb_mask = '0;
    all_zero = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      all_zero    = all_zero && (nib[k] == 4'h0);
      lzb_mask[k] = all_zero;
    end
  end
`else
  assign lzb_mask = '0;
`endif

  assign slot_end = (pcnt_q == PCNT_LAST);
  assign wrap     = slot_end && (idx_q == IDX_LAST);
  assign in_blank = int'(pcnt_q) < BLANK_CYC;

  always_comb begin
    pcnt_d = slot_end ? '0 : pcnt_q + PW'(1);
    idx_d  = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    an_d   = '1;
    seg_d  = 7'h7F;
    dp_n_d = 1'b1;
    if (!in_blank && en_ext[idx_q]) begin
      if (lzb_mask[idx_q]) begin
        // A suppressed leading zero keeps its decimal point visible.
        if (dp_ext[idx_q]) begin
          an_d   = ~(NDIG'(1) << idx_q);
          dp_n_d = 1'b0;
        end
      end else begin
        an_d   = ~(NDIG'(1) << idx_q);
        seg_d  = decode(nib[idx_q]);
        dp_n_d = ~dp_ext[idx_q];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      dp_q         <= '0;
      en_q         <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_n_q       <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      if (bus.load) begin
        data_q <= bus.data;
        dp_q   <= bus.dp;
        en_q   <= bus.dig_en;
      end
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      frame_tick_q <= wrap;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_d7seg_scan.sv
// Scoreboard bench for d7seg_scan: stimulus pushes the expected display state per edge, a negedge monitor pops and compares.
// The reference derives slot and digit from the elapsed cycle count rather than from counters.
module tb_d7seg_scan;
  localparam int NDIG      = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = NDIG * SCAN_DIV;

  typedef struct packed {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        ft;
    logic [31:0] t;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  d7seg_scan_if #(.NDIG(NDIG)) bus ();

  d7seg_scan #(
    .NDIG(NDIG),
    .SCAN_DIV(SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          t;
  logic [15:0] sh_d;
  logic [3:0]  sh_p;
  logic [3:0]  sh_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, req, t);
  endtask

  // Display state after the edge that ends cycle tt, given the shadow word held during tt.
  function automatic exp_t model(input int tt, input logic [15:0] d, input logic [3:0] p,
                                 input logic [3:0] e);
    exp_t r;
    int pc, ix;
    logic [3:0] nv;
    pc     = tt % SCAN_DIV;
    ix     = (tt / SCAN_DIV) % NDIG;
    r.t    = tt;
    r.ft   = (tt % FRAME) == FRAME - 1;
    r.an   = 4'hF;
    r.seg  = 7'h7F;
    r.dp_n = 1'b1;
    if (pc >= BLANK_CYC && e[ix]) begin
      nv     = d[ix*4 +: 4];
      r.an   = 4'hF ^ (4'h1 << ix);
      r.seg  = seg_tab[nv];
      r.dp_n = !p[ix];
    end
    return r;
  endfunction

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    bus.load   = ld;
    bus.data   = d;
    bus.dp     = p;
    bus.dig_en = e;
    @(posedge clk);
    exp_q.push_back(model(t, sh_d, sh_p, sh_e));
    if (ld) begin
      sh_d = d;
      sh_p = p;
      sh_e = e;
      $display("load t=%0d data=%h dp=%b dig_en=%b", t, d, p, e);
    end
    t++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("an", 32'(bus.an), 32'(e.an));
      check("seg", 32'(bus.seg), 32'(e.seg));
      check("dp_n", 32'(bus.dp_n), 32'(e.dp_n));
      check("frame_tick", 32'(bus.frame_tick), 32'(e.ft));
      check("one_anode", 32'($countones(~bus.an) <= 1), 32'd1);
    end
  end

  initial begin
    bus.load   = 1'b0;
    bus.data   = '0;
    bus.dp     = '0;
    bus.dig_en = '0;
    t    = 0;
    sh_d = '0;
    sh_p = '0;
    sh_e = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_dp_n", 32'(bus.dp_n), 32'd1);
    check("rst_ft", 32'(bus.frame_tick), 32'd0);
    rst_n = 1'b1;
    idle(64);

    step(1'b1, 16'h3210, 4'b0100, 4'hF);
    idle(FRAME - 1);
    step(1'b1, 16'h7654, 4'b1010, 4'hF);
    idle(FRAME - 1);
    step(1'b1, 16'hBA98, 4'b0001, 4'hF);
    idle(FRAME - 1);
    step(1'b1, 16'hFEDC, 4'b1000, 4'hF);
    idle(FRAME - 1);

    step(1'b1, 16'h1111, 4'b0000, 4'hF);
    while (t % FRAME != SCAN_DIV + 4) idle(1);
    step(1'b1, 16'h2222, 4'b0000, 4'hF);
    idle(FRAME);

    step(1'b1, 16'h0050, 4'b0000, 4'b1101);
    idle(2 * FRAME);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else idle(1);
    end

    // Land just after digit 2 / pcnt 5 is entered, past the monitor's negedge.
    step(1'b1, 16'h9876, 4'b1111, 4'hF);
    while (t % FRAME != 2 * SCAN_DIV + 5) idle(1);
    #5;
    rst_n = 1'b0;
    #1;
    check("async_an", 32'(bus.an), 32'hF);
    check("async_seg", 32'(bus.seg), 32'h7F);
    check("async_dp_n", 32'(bus.dp_n), 32'd1);
    check("async_ft", 32'(bus.frame_tick), 32'd0);
    check("async_queue", 32'(exp_q.size()), 32'd0);
    t    = 0;
    sh_d = '0;
    sh_p = '0;
    sh_e = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(16);
    step(1'b1, 16'h3210, 4'b0000, 4'hF);
    idle(FRAME);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
